// File: rtl/ysyx_2022040010_lsu_if.sv
// rtl/ysyx_2022040010_lsu_if.sv - pipeline and data-memory bus signals of the load/store unit
interface ysyx_2022040010_lsu_if;
    logic        ex_valid;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;

    modport master (
        input  ex_valid, ex_we, ex_size, ex_unsigned, ex_addr, ex_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output resp_valid, resp_data, resp_err
    );

    modport slave (
        output ex_valid, ex_we, ex_size, ex_unsigned, ex_addr, ex_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/ysyx_2022040010_lsu.sv
// rtl/ysyx_2022040010_lsu.sv - load/store unit: aligned bus request, lane extraction, timeout
module ysyx_2022040010_lsu #(
    parameter int TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_2022040010_lsu_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [CW-1:0] r_cnt;
    logic [63:0] r_resp_data;
    logic        r_resp_err;

    logic        w_misaligned;
    logic        w_limit;
    logic [7:0]  w_base_mask;
    logic [63:0] w_lane;
    logic [63:0] w_load_data;

    always_comb begin
        w_misaligned = 1'b0;
        w_base_mask  = 8'h01;
        case (bus.ex_size)
            2'd0: begin w_misaligned = 1'b0;                w_base_mask = 8'h01; end
            2'd1: begin w_misaligned = bus.ex_addr[0];      w_base_mask = 8'h03; end
            2'd2: begin w_misaligned = |bus.ex_addr[1:0];   w_base_mask = 8'h0F; end
            default: begin w_misaligned = |bus.ex_addr[2:0]; w_base_mask = 8'hFF; end
        endcase
    end

    // The addressed lane is moved down to bit 0 before size extraction.
    assign w_lane = bus.mem_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_load_data = w_lane;
        case (r_size)
            2'd0: w_load_data = r_unsigned ? {56'b0, w_lane[7:0]}  : {{56{w_lane[7]}},  w_lane[7:0]};
            2'd1: w_load_data = r_unsigned ? {48'b0, w_lane[15:0]} : {{48{w_lane[15]}}, w_lane[15:0]};
            2'd2: w_load_data = r_unsigned ? {32'b0, w_lane[31:0]} : {{32{w_lane[31]}}, w_lane[31:0]};
            default: w_load_data = w_lane;
        endcase
    end

    assign w_limit = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.stall      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 64'h0;
        bus.mem_wstrb  = 8'h0;
        bus.mem_wdata  = 64'h0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 64'h0;
        bus.resp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.stall = bus.ex_valid;
                if (bus.ex_valid) begin
                    w_next = w_misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                bus.stall     = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = {r_addr[63:3], 3'b000};
                bus.mem_wstrb = r_wstrb;
                bus.mem_wdata = r_wdata;
                if (bus.mem_gnt) begin
                    w_next = S_WAIT;
                end else if (w_limit) begin
                    w_next = S_RESP;
                end
            end
            S_WAIT: begin
                bus.stall = 1'b1;
                if (bus.mem_rvalid) begin
                    w_next = S_RESP;
                end else if (w_limit) begin
                    w_next = S_RESP;
                end
            end
            default: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = r_resp_data;
                bus.resp_err   = r_resp_err;
                w_next         = S_IDLE;
            end
        endcase
    end

    // Completion in the limit cycle takes priority over the timeout abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= 64'h0;
            r_wdata     <= 64'h0;
            r_wstrb     <= 8'h0;
            r_cnt       <= '0;
            r_resp_data <= 64'h0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ex_valid) begin
                        r_we        <= bus.ex_we;
                        r_unsigned  <= bus.ex_unsigned;
                        r_size      <= bus.ex_size;
                        r_addr      <= bus.ex_addr;
                        r_wdata     <= bus.ex_wdata << {bus.ex_addr[2:0], 3'b000};
                        r_wstrb     <= bus.ex_we ? (w_base_mask << bus.ex_addr[2:0]) : 8'h0;
                        r_cnt       <= '0;
                        r_resp_data <= 64'h0;
                        r_resp_err  <= w_misaligned;
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (!bus.mem_gnt && w_limit) begin
                        r_resp_data <= 64'h0;
                        r_resp_err  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (bus.mem_rvalid) begin
                        r_resp_data <= r_we ? 64'h0 : w_load_data;
                        r_resp_err  <= 1'b0;
                    end else if (w_limit) begin
                        r_resp_data <= 64'h0;
                        r_resp_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_2022040010_lsu.sv
// tb/tb_ysyx_2022040010_lsu.sv - scoreboard bench for the load/store unit with a byte-level memory model
module tb_ysyx_2022040010_lsu;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_2022040010_lsu_if bus ();
    ysyx_2022040010_lsu #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [63:0] data;
        logic        err;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  strb;
        logic [63:0] wdata;
        int          cycles;
    } req_t;

    resp_t       rq[$];
    req_t        qq[$];
    logic [7:0]  ref_mem [0:127];
    logic [63:0] bus_mem [0:15];
    int          gnt_delay = 0;
    int          rv_delay  = 1;
    int          total = 0;
    int          bad   = 0;
    longint      cyc = 0;
    longint      resp_last = 0;
    longint      resp_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_line(input int idx, input logic [63:0] v);
        bus_mem[idx] = v;
        for (int i = 0; i < 8; i++) ref_mem[idx*8+i] = v[8*i +: 8];
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] a, input int size, input logic uns);
        int n = 1 << size;
        logic [63:0] v = 64'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'((a + 64'(i)) & 64'd127)];
        if (!uns && n < 8 && v[8*n-1]) begin
            for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one op as the pipeline would: hold it while stall is high, retire it after the RESP cycle.
    task automatic issue(input logic we, input int size, input logic uns, input logic [63:0] addr,
                         input logic [63:0] wdata, input int gd, input int rd);
        int    n   = 1 << size;
        int    off = int'(addr[2:0]);
        bit    mis;
        bit    tmo;
        resp_t e;
        req_t  r;
        int    sc;
        int    exp_sc;
        mis = (off % n) != 0;
        tmo = !mis && (gd < 0 || gd + 1 + rd > TO);
        gnt_delay = gd;
        rv_delay  = rd;
        e.err  = mis || tmo;
        e.data = 64'h0;
        if (!e.err && !we) e.data = ref_load(addr, size, uns);
        if (!e.err && we) begin
            for (int i = 0; i < n; i++) ref_mem[int'((addr + 64'(i)) & 64'd127)] = wdata[8*i +: 8];
        end
        if (!mis) begin
            r.addr  = addr & ~64'h7;
            r.we    = we;
            r.strb  = 8'h0;
            r.wdata = 64'h0;
            if (we) begin
                for (int i = 0; i < n; i++) r.strb[off+i] = 1'b1;
            end
            for (int j = off; j < 8; j++) r.wdata[8*j +: 8] = wdata[8*(j-off) +: 8];
            r.cycles = (gd < 0) ? TO : gd + 1;
            qq.push_back(r);
        end
        rq.push_back(e);
        exp_sc = mis ? 1 : (tmo ? 1 + TO : 2 + gd + rd);
        bus.ex_we       = we;
        bus.ex_size     = 2'(size);
        bus.ex_unsigned = uns;
        bus.ex_addr     = addr;
        bus.ex_wdata    = wdata;
        bus.ex_valid    = 1'b1;
        sc = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall) break;
            sc++;
            if (sc > 60) break;
        end
        check("stall_cycles", 64'(sc), 64'(exp_sc));
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
    endtask

    // Bus slave: grants after gnt_delay cycles (never if negative), answers rv_delay cycles after the grant.
    initial begin : bus_model
        int ph = 0;
        int cnt = 0;
        int line = 0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'h0;
        forever begin
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = {$urandom, $urandom};
            if (ph == 0 && bus.mem_req === 1'b1) begin
                ph  = 1;
                cnt = 0;
            end
            if (ph == 1) begin
                if (bus.mem_req !== 1'b1) begin
                    ph = 0;
                end else if (gnt_delay >= 0 && cnt == gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    ph   = 2;
                    cnt  = 0;
                    line = int'(bus.mem_addr[6:3]);
                    if (bus.mem_we) begin
                        for (int i = 0; i < 8; i++)
                            if (bus.mem_wstrb[i]) bus_mem[line][8*i +: 8] = bus.mem_wdata[8*i +: 8];
                    end
                end else begin
                    cnt++;
                end
            end else if (ph == 2) begin
                cnt++;
                if (cnt == rv_delay) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = bus_mem[line];
                    ph = 0;
                end
            end
        end
    end

    initial begin : monitor
        int    in_req = 0;
        int    rcnt = 0;
        req_t  cur;
        resp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.resp_valid === 1'b1) begin
                resp_prev = resp_last;
                resp_last = cyc;
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got data %h err %b expected no response", bus.resp_data, bus.resp_err);
                end else begin
                    e = rq.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_err", 64'(bus.resp_err), 64'(e.err));
                end
            end
            if (bus.mem_req === 1'b1) begin
                if (in_req == 0) begin
                    if (qq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got addr %h expected no request", bus.mem_addr);
                    end else begin
                        cur    = qq.pop_front();
                        in_req = 1;
                        rcnt   = 0;
                    end
                end
                if (in_req != 0) begin
                    rcnt++;
                    check("req_addr", bus.mem_addr, cur.addr);
                    check("req_we", 64'(bus.mem_we), 64'(cur.we));
                    check("req_wstrb", 64'(bus.mem_wstrb), 64'(cur.strb));
                    if (cur.we) check("req_wdata", bus.mem_wdata, cur.wdata);
                end
            end else if (in_req != 0) begin
                check("req_cycles", 64'(rcnt), 64'(cur.cycles));
                in_req = 0;
            end
        end
    end

    initial begin : stimulus
        logic [63:0] a;
        int          sz;
        rst             = 1'b1;
        bus.ex_valid    = 1'b0;
        bus.ex_we       = 1'b0;
        bus.ex_size     = 2'd0;
        bus.ex_unsigned = 1'b0;
        bus.ex_addr     = 64'h0;
        bus.ex_wdata    = 64'h0;
        for (int i = 0; i < 16; i++) set_line(i, {$urandom, $urandom});
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'h0);
        check("rst_mem_req", 64'(bus.mem_req), 64'h0);
        check("rst_mem_bus", {bus.mem_addr[55:0], bus.mem_wstrb} | bus.mem_wdata | 64'(bus.mem_we), 64'h0);
        check("rst_resp", bus.resp_data | 64'(bus.resp_valid) | 64'(bus.resp_err), 64'h0);
        step(1);

        set_line(0, 64'h8877665544332211);
        issue(1'b0, 0, 1'b0, 64'h2007, 64'h0, 0, 1);
        issue(1'b0, 0, 1'b1, 64'h2003, 64'h0, 0, 1);
        issue(1'b1, 2, 1'b0, 64'h1004, 64'hDEADBEEF, 3, 1);
        issue(1'b0, 2, 1'b1, 64'h1004, 64'h0, 1, 2);
        issue(1'b0, 1, 1'b0, 64'h1001, 64'h0, 0, 1);
        issue(1'b0, 2, 1'b0, 64'h1002, 64'h0, 0, 1);
        issue(1'b0, 3, 1'b0, 64'h1004, 64'h0, 0, 1);

        issue(1'b1, 3, 1'b0, 64'h0018, 64'h1122334455667788, -1, 1);
        step(3);
        issue(1'b0, 3, 1'b0, 64'h0018, 64'h0, 3, 4);
        issue(1'b0, 1, 1'b0, 64'h0026, 64'h0, 3, 5);
        step(8);

        gnt_delay = 0;
        rv_delay  = 6;
        qq.push_back('{addr: 64'h40, we: 1'b0, strb: 8'h0, wdata: 64'h0, cycles: 1});
        bus.ex_we       = 1'b0;
        bus.ex_size     = 2'd3;
        bus.ex_unsigned = 1'b0;
        bus.ex_addr     = 64'h40;
        bus.ex_valid    = 1'b1;
        step(2);
        rst          = 1'b1;
        bus.ex_valid = 1'b0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_wait_req", 64'(bus.mem_req), 64'h0);
        check("rst_mid_wait_stall", 64'(bus.stall), 64'h0);
        step(10);
        set_line(0, 64'h0123456789ABCDEF);
        issue(1'b0, 3, 1'b0, 64'h0, 64'h0, 0, 1);

        issue(1'b1, 3, 1'b0, 64'h0030, 64'hCAFEF00D12345678, 0, 1);
        issue(1'b0, 3, 1'b0, 64'h0030, 64'h0, 0, 1);
        check("b2b_resp_spacing", 64'(resp_last - resp_prev), 64'd4);

        for (int k = 0; k < 60; k++) begin
            sz = int'($urandom_range(0, 3));
            a  = {$urandom, $urandom} & ~64'd127;
            a  = a | 64'($urandom_range(0, 127));
            if ($urandom_range(0, 4) != 0) a = a & ~64'((1 << sz) - 1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                  {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        step(5);
        check("resp_queue_drained", 64'(rq.size()), 64'h0);
        check("req_queue_drained", 64'(qq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_2022040010_lsu.md
# ysyx_2022040010_lsu

Load/store unit sitting directly upstream of the memory stage: takes one memory operation per instruction from the execute stage, turns it into an 8-byte-aligned request on the data-memory bus, and returns the size-extracted, sign/zero-extended load result (or store acknowledge) to the pipeline. The variable-latency bus handshake is handled through a small FSM. The pipeline is stalled until the access completes, faults on misalignment, or times out.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before the access is aborted with an error; ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  memory op present from EX this cycle
- ex_we  in  1  1 = store, 0 = load
- ex_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- ex_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
- ex_addr  in  64  byte address
- ex_wdata  in  64  store data, right-aligned
- stall  out  1  hold EX and everything upstream
- mem_req  out  1  bus request
- mem_we  out  1  write request
- mem_addr  out  64  {addr[63:3], 3'b0}
- mem_wstrb  out  8  byte enables (stores); 0 for loads
- mem_wdata  out  64  store data shifted into lane position
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data / write ack valid
- mem_rdata  in  64  read data, full 8-byte line
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  64  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned or timed out

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: when ex_valid, latch we, size, unsigned, addr and wdata; clear the timeout counter.
  - Misaligned (half addr[0]≠0; word addr[1:0]≠0; double addr[2:0]≠0): go to RESP with err=1 and issue no bus request.
  - Otherwise go to REQ.
- Strobe: base mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
- Store data: ex_wdata << (8·addr[2:0]), truncated to 64 bits.
- REQ: mem_req=1. Hold mem_we, mem_addr, mem_wstrb and mem_wdata stable from the latched values. On mem_gnt go to WAIT.
- WAIT: mem_req=0. On mem_rvalid, extract the lane at addr[2:0] by size, extend it (sign unless unsigned; double passes through), register it as the result, and go to RESP. Stores use rvalid as the write ack and produce result 0.
- Timeout: the counter increments every cycle in REQ or WAIT. If the counter equals TIMEOUT−1 and that cycle's completing event (gnt in REQ, rvalid in WAIT) is absent, go to RESP with err=1 and result 0. If the completing event arrives in the same cycle as the limit, normal completion wins.
- RESP: resp_valid=1, with resp_data and resp_err from registers. Go to IDLE unconditionally.
- stall = (IDLE & ex_valid) | REQ | WAIT. stall is low in RESP, so the pipeline advances at the end of RESP. The same instruction still visible on ex_* during RESP is not re-accepted.
- mem_rvalid seen in IDLE, REQ or RESP is ignored. The bus guarantees rvalid no earlier than the cycle after gnt.

## Timing
- Reset: state IDLE, counter 0. stall follows IDLE & ex_valid. mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid, resp_data and resp_err are all 0.
- Reset mid-operation (REQ/WAIT/RESP): state is IDLE after the edge and mem_req drops. The access is abandoned and no resp_valid is produced.
- Zero-wait bus (gnt in the first REQ cycle, rvalid on the next cycle):
  - cycle 0 IDLE accept, stall=1
  - cycle 1 REQ + gnt
  - cycle 2 WAIT + rvalid
  - cycle 3 RESP, resp_valid=1, stall=0
  - Total latency 3 cycles from accept to response; stall high for 3 cycles.
- Misaligned: accept at cycle 0, RESP at cycle 1, stall high for 1 cycle.
- Back-to-back: a new op is accepted in the IDLE cycle immediately following RESP, with no bubble beyond the RESP cycle.
- Outputs in RESP are registered. stall is combinational from state and ex_valid.

## Test plan
- Load byte extension: lb, addr 0x2007, rdata 0x8877665544332211 → mem_addr 0x2000, mem_wstrb 0, resp_data 0xFFFFFFFFFFFFFF88. Repeat as lbu at 0x2003 → resp_data 0x44. Zero-wait timing: stall high for exactly 3 cycles.
- Store word: sw, addr 0x1004, wdata 0xDEADBEEF → mem_addr 0x1000, mem_wstrb 0xF0, mem_wdata[63:32]=0xDEADBEEF. With gnt delayed 3 cycles, mem_req stays high and stable for 4 cycles. rvalid then gives resp_valid=1, resp_data 0.
- Misaligned: lh at 0x1001 → mem_req never asserted; resp_valid and resp_err at cycle 1. Also check lw at 0x1002 and ld at 0x1004 → err.
- Timeout: TIMEOUT=8 with gnt never asserted → mem_req high for exactly 8 cycles, then resp_err=1, resp_data 0. Also check rvalid arriving exactly on the limit cycle → normal completion with err=0.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT → IDLE, no resp_valid. A late rvalid afterwards is ignored, and the next ld at 0x0 with rdata 0x0123456789ABCDEF returns resp_data 0x0123456789ABCDEF.
- Back-to-back: sd then ld at the same address, with a bus model that returns written data → second resp_data equals the stored value, and exactly one IDLE cycle separates the RESPs.
